// File: rtl/counter_pkg.sv
// counter_pkg: shared types and defaults for the team's counter blocks.
//   dc_state_t       - down-counter control state (IDLE/RUN/DONE)
//   DC_WIDTH_DEFAULT - default counter width
package counter_pkg;

  localparam int unsigned DC_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dc_state_t;

endpackage : counter_pkg

// File: rtl/dn_tff_cell.sv
// dn_tff_cell: falling-edge toggle cell with asynchronous active-low clear.
//   t   - toggle request, sampled on the falling edge of clk
//   clk - clock
//   rst - asynchronous active-low clear
//   q   - stored bit
module dn_tff_cell (
  input  logic t,
  input  logic clk,
  input  logic rst,
  output logic q
);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule : dn_tff_cell

// File: rtl/sync_downcounter.sv
// sync_downcounter: loadable down-counter built from toggle cells with a
// borrow chain. Runs a loaded count N down to zero and pulses done.
// All state updates on the falling edge of clk.
//   WIDTH    - counter width (2..16)
//   clk      - clock (falling-edge active)
//   rst      - asynchronous active-low reset
//   en       - count enable
//   load     - load strobe (priority over en and terminal handling)
//   load_val - start value N
//   q        - current count
//   busy     - high while counting (state RUN)
//   done     - one-cycle completion pulse
// Build option: define SYNC_DOWNCOUNTER_RELOAD_EN for periodic mode (terminal
// step reloads the last loaded N); otherwise one-shot mode ending in DONE.
module sync_downcounter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  dc_state_t        state_q, state_d;
  logic             done_d;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] borrow_tog;
`ifdef SYNC_DOWNCOUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_reg_q, reload_reg_d;
`endif

  // Bit i toggles when every lower bit is 0; bit 0 always toggles.
  always_comb begin
    borrow_tog    = '0;
    borrow_tog[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      borrow_tog[i] = borrow_tog[i-1] & ~q[i-1];
    end
  end

  // Arbitrary targets are reached by toggling the bits that differ (q ^ target).
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    tog     = '0;
`ifdef SYNC_DOWNCOUNTER_RELOAD_EN
    reload_reg_d = reload_reg_q;
`endif
    if (load) begin
      tog = q ^ load_val;
`ifdef SYNC_DOWNCOUNTER_RELOAD_EN
      reload_reg_d = load_val;
`endif
      if (load_val != '0) begin
        state_d = RUN;
      end else begin
        done_d = 1'b1;
`ifdef SYNC_DOWNCOUNTER_RELOAD_EN
        state_d = IDLE;
`else
        state_d = DONE;
`endif
      end
    end else if (state_q == RUN && en) begin
      if (q == WIDTH'(1)) begin
        done_d = 1'b1;
`ifdef SYNC_DOWNCOUNTER_RELOAD_EN
        tog = q ^ reload_reg_q;
`else
        // Borrow chain from 1 clears bit 0 only, landing exactly on 0.
        tog     = borrow_tog;
        state_d = DONE;
`endif
      end else begin
        tog = borrow_tog;
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SYNC_DOWNCOUNTER_RELOAD_EN
      reload_reg_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= done_d;
`ifdef SYNC_DOWNCOUNTER_RELOAD_EN
      reload_reg_q <= reload_reg_d;
`endif
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    dn_tff_cell u_cell (
      .t  (tog[i]),
      .clk(clk),
      .rst(rst),
      .q  (q[i])
    );
  end

endmodule : sync_downcounter

// File: tb/tb_sync_downcounter.sv
// tb_sync_downcounter: directed plus randomized stimulus for sync_downcounter,
// checked every cycle against a behavioural count model.
module tb_sync_downcounter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  // Behavioural model: plain integer count and a running flag.
  int m_q;
  int m_reload;
  bit m_run;
  bit m_done;

  sync_downcounter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_reload = 0; m_run = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit e, input bit ld, input int lv);
    m_done = 0;
    if (ld) begin
      m_q = lv;
      m_reload = lv;
      m_run = (lv != 0);
      m_done = (lv == 0);
    end else if (m_run && e) begin
      if (m_q == 1) begin
        m_done = 1;
`ifdef SYNC_DOWNCOUNTER_RELOAD_EN
        m_q = m_reload;
`else
        m_q = 0;
        m_run = 0;
`endif
      end else begin
        m_q = m_q - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, int'(q), m_q);
    check({tag, ".busy"}, int'(busy), int'(m_run));
    check({tag, ".done"}, int'(done), int'(m_done));
  endtask

  // One falling edge: drive, let the edge happen, then compare 2 ns later.
  task automatic step(input string tag, input bit e, input bit ld, input int lv);
    en = e; load = ld; load_val = W'(lv);
    @(negedge clk);
    model_edge(e, ld, lv);
    #2;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    model_reset();
    check_all("rst");
    @(posedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    #1;
    do_reset();

    // Reset mid-count
    step("rmc_ld", 1, 1, 9);
    for (int i = 0; i < 3; i++) step("rmc_run", 1, 0, 0);
    #1 do_reset();
    step("rmc_idle", 1, 0, 0);

    // One-shot count from 5
    step("os_ld", 1, 1, 5);
    for (int i = 0; i < 5; i++) step("os_run", 1, 0, 0);
    for (int i = 0; i < 3; i++) step("os_hold", 1, 0, 0);

    // Enable gating
    step("eg_ld", 0, 1, 3);
    step("eg1", 1, 0, 0);
    step("eg2", 0, 0, 0);
    step("eg3", 0, 0, 0);
    step("eg4", 1, 0, 0);
    step("eg5", 1, 0, 0);

    // Load collides with the terminal step
    step("lc_ld", 1, 1, 2);
    step("lc_run", 1, 0, 0);
    step("lc_hit", 1, 1, 7);
    check("lc_q7", int'(q), 7);
    check("lc_nodone", int'(done), 0);

    // Maximum count
    step("max_ld", 1, 1, MAXV);
    for (int i = 0; i < MAXV; i++) step("max_run", 1, 0, 0);
`ifndef SYNC_DOWNCOUNTER_RELOAD_EN
    check("max_nowrap", int'(q), 0);
`else
    check("max_reload", int'(q), MAXV);
`endif
    step("max_after", 1, 0, 0);

    // Zero load
    step("z_ld", 1, 1, 0);
    check("z_done", int'(done), 1);
    check("z_busy", int'(busy), 0);
    step("z_after", 1, 0, 0);

    // Periodic sequence from 3 (one-shot build checks the same via model)
    step("per_ld", 1, 1, 3);
    for (int i = 0; i < 9; i++) step("per_run", 1, 0, 0);

    // Randomized stimulus
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      int lv;
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0: lv = 0;
        1: lv = MAXV;
        default: lv = int'($urandom_range(1, MAXV));
      endcase
      if (r < 2) begin
        @(posedge clk);
        #1 do_reset();
      end else begin
        step("rnd", $urandom_range(0, 3) != 0, r < 10, lv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_sync_downcounter
